// File: rtl/mul_err_sweep.sv
// Exhaustive error sweep for an approximate WIDTH x WIDTH unsigned multiplier.
// Optional per-bit error histogram is enabled by defining MUL_ERR_BITHIST_EN.
module mul_err_sweep #(
   parameter int WIDTH = 6,
   parameter int SUM_W = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [WIDTH-1:0]       op_a,
   output logic [WIDTH-1:0]       op_b,
   input  logic [2*WIDTH-1:0]     approx_p,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH:0]       err_count,
   output logic [SUM_W-1:0]       sum_abs_err,
   output logic [2*WIDTH-1:0]     max_abs_err
`ifdef MUL_ERR_BITHIST_EN
   ,
   output logic [2*WIDTH*(2*WIDTH+1)-1:0] bit_err_hist
`endif
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = PW + 1;
   localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic            clear;
   logic            drain_q;
   logic [PW-1:0]   cnt_q;

   logic            s1_valid;
   logic [PW-1:0]   s1_approx;
   logic [PW-1:0]   s1_exact;
   logic            s2_valid;
   logic [PW-1:0]   s2_diff;
   logic [PW-1:0]   s2_flip;
   logic [AW-1:0]   sum_next;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SWEEP;
               clear   = 1'b1;
            end
         end
         SWEEP:   if (cnt_q == '1) state_d = DRAIN;
         DRAIN:   if (drain_q) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         drain_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == DRAIN);
         if (clear)
            cnt_q <= '0;
         else if (state_q == SWEEP)
            cnt_q <= cnt_q + PW'(1);
      end
   end

   assign op_a = cnt_q[WIDTH-1:0];
   assign op_b = cnt_q[PW-1:WIDTH];
   assign busy = (state_q == SWEEP) || (state_q == DRAIN);
   assign done = (state_q == DONE);

   // Stage 1 samples the returned product alongside the exact one; stage 2 forms |diff|.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_approx <= '0;
         s1_exact  <= '0;
         s2_valid  <= 1'b0;
         s2_diff   <= '0;
         s2_flip   <= '0;
      end else begin
         s1_valid  <= (state_q == SWEEP);
         s1_approx <= approx_p;
         s1_exact  <= PW'(op_a) * PW'(op_b);
         s2_valid  <= s1_valid;
         s2_diff   <= (s1_approx >= s1_exact) ? (s1_approx - s1_exact)
                                              : (s1_exact - s1_approx);
         s2_flip   <= s1_approx ^ s1_exact;
      end
   end

   assign sum_next = AW'(sum_abs_err) + AW'(s2_diff);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         err_count   <= '0;
         sum_abs_err <= '0;
         max_abs_err <= '0;
      end else if (s2_valid) begin
         if (s2_diff != '0)
            err_count <= err_count + CW'(1);
         // Any carry past SUM_W bits pins the accumulator at all-ones for good.
         if (|sum_next[AW-1:SUM_W])
            sum_abs_err <= '1;
         else
            sum_abs_err <= sum_next[SUM_W-1:0];
         if (s2_diff > max_abs_err)
            max_abs_err <= s2_diff;
      end
   end

`ifdef MUL_ERR_BITHIST_EN
   logic [CW-1:0] hist_q [PW];

   // NOTE: the histogram array is small and its clear is functional, so it is reset like any register.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < PW; i++) hist_q[i] <= '0;
      end else if (s2_valid) begin
         for (int i = 0; i < PW; i++) hist_q[i] <= hist_q[i] + CW'(s2_flip[i]);
      end
   end

   for (genvar g = 0; g < PW; g++) begin : g_hist
      assign bit_err_hist[g*CW +: CW] = hist_q[g];
   end
`else
   logic unused_flip;
   assign unused_flip = ^s2_flip;
`endif

endmodule

// File: tb/tb_mul_err_sweep.sv
// Self-checking bench for mul_err_sweep: randomized and fixed approximate multipliers
// scored against a whole-sweep arithmetic reference; a second instance uses SUM_W = 12.
module tb_mul_err_sweep;

   localparam int W   = 6;
   localparam int PW  = 2 * W;
   localparam int CW  = PW + 1;
   localparam int NV  = 1 << PW;
   localparam int SW  = 24;
   localparam int SWS = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   int   mode = 0;

   logic [W-1:0]   op_a, op_b, op_a_s, op_b_s;
   logic [PW-1:0]  approx_p, approx_p_s;
   logic           busy, done, busy_s, done_s;
   logic [CW-1:0]  err_count, err_count_s;
   logic [SW-1:0]  sum_abs_err;
   logic [SWS-1:0] sum_abs_err_s;
   logic [PW-1:0]  max_abs_err, max_abs_err_s;
`ifdef MUL_ERR_BITHIST_EN
   logic [PW*CW-1:0] bit_err_hist, bit_err_hist_s;
`endif

   logic [PW-1:0] rnd_mask [NV];

   int errors = 0;
   int checks = 0;

   longint exp_err, exp_sum, exp_sum_sat, exp_max;
   longint exp_hist [PW];

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] approx_of(int m, int a, int b);
      int p;
      p = a * b;
      case (m)
         0:       return PW'(p);
         1:       return '0;
         2:       return PW'(p + 1);
         default: return PW'(p) ^ rnd_mask[b * (1 << W) + a];
      endcase
   endfunction

   assign approx_p   = approx_of(mode, int'(op_a), int'(op_b));
   assign approx_p_s = approx_of(mode, int'(op_a_s), int'(op_b_s));

   mul_err_sweep #(.WIDTH(W), .SUM_W(SW)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .op_a(op_a), .op_b(op_b), .approx_p(approx_p),
      .busy(busy), .done(done),
      .err_count(err_count), .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
`ifdef MUL_ERR_BITHIST_EN
      , .bit_err_hist(bit_err_hist)
`endif
   );

   mul_err_sweep #(.WIDTH(W), .SUM_W(SWS)) u_sat (
      .clk(clk), .rst(rst), .start(start),
      .op_a(op_a_s), .op_b(op_b_s), .approx_p(approx_p_s),
      .busy(busy_s), .done(done_s),
      .err_count(err_count_s), .sum_abs_err(sum_abs_err_s), .max_abs_err(max_abs_err_s)
`ifdef MUL_ERR_BITHIST_EN
      , .bit_err_hist(bit_err_hist_s)
`endif
   );

   // Reference: walk every operand pair with plain integer arithmetic.
   task automatic build_expected(input int m);
      longint ex, ap, d;
      logic [PW-1:0] exv, apv;
      exp_err = 0; exp_sum = 0; exp_max = 0;
      for (int h = 0; h < PW; h++) exp_hist[h] = 0;
      for (int a = 0; a < (1 << W); a++) begin
         for (int b = 0; b < (1 << W); b++) begin
            ex  = a * b;
            apv = approx_of(m, a, b);
            ap  = longint'(apv);
            exv = PW'(ex);
            d   = (ap > ex) ? ap - ex : ex - ap;
            if (d != 0) exp_err++;
            exp_sum += d;
            if (d > exp_max) exp_max = d;
            for (int h = 0; h < PW; h++) if (apv[h] != exv[h]) exp_hist[h]++;
         end
      end
      exp_sum_sat = (exp_sum > (2**SWS - 1)) ? (2**SWS - 1) : exp_sum;
      if (exp_sum > (2**SW - 1)) exp_sum = 2**SW - 1;
   endtask

   // Pulses start, then samples once per cycle (after edge N+i) until done or budget expiry.
   task automatic run_sweep(input int repulse_at, output int latency, output int busy_cnt,
                            output bit op_ok, output longint err_at_start);
      latency = -1; busy_cnt = 0; op_ok = 1'b1; err_at_start = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         start = (i == repulse_at);
         if (i == 0) err_at_start = longint'(err_count);
         if (done) begin
            latency = i;
            break;
         end
         if (busy) busy_cnt++;
         if (i < NV && {op_b, op_a} != PW'(i)) op_ok = 1'b0;
         @(posedge clk);
      end
      start = 1'b0;
   endtask

   task automatic sweep_scenario(input string name, input int m, input int repulse_at);
      int latency, busy_cnt;
      bit op_ok;
      longint err_at_start;
      logic [CW-1:0] hold_err;
      logic [SW-1:0] hold_sum;
      logic [PW-1:0] hold_max;
      mode = m;
      build_expected(m);
      run_sweep(repulse_at, latency, busy_cnt, op_ok, err_at_start);
      checks++;
      if (latency !== NV + 2) begin
         errors++;
         $display("FAIL %s done_latency got=%0d want=%0d", name, latency, NV + 2);
      end
      if (latency < 0) return;
      // busy spans the start edge up to the edge where done rises.
      checks++;
      if (busy_cnt !== NV + 2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_span got=%0d busy_at_done=%b want=%0d/0", name, busy_cnt, busy, NV + 2);
      end
      checks++;
      if (op_ok !== 1'b1) begin
         errors++;
         $display("FAIL %s operand_order got=bad want=ok", name);
      end
      checks++;
      if (longint'(err_count) !== exp_err) begin
         errors++;
         $display("FAIL %s err_count got=%0d want=%0d", name, err_count, exp_err);
      end
      checks++;
      if (longint'(sum_abs_err) !== exp_sum) begin
         errors++;
         $display("FAIL %s sum_abs_err got=%0d want=%0d", name, sum_abs_err, exp_sum);
      end
      checks++;
      if (longint'(max_abs_err) !== exp_max) begin
         errors++;
         $display("FAIL %s max_abs_err got=%0d want=%0d", name, max_abs_err, exp_max);
      end
      checks++;
      if (longint'(err_count_s) !== exp_err || longint'(sum_abs_err_s) !== exp_sum_sat || done_s !== 1'b1) begin
         errors++;
         $display("FAIL %s sat12 got err=%0d sum=%0d done=%b want err=%0d sum=%0d done=1",
                  name, err_count_s, sum_abs_err_s, done_s, exp_err, exp_sum_sat);
      end
`ifdef MUL_ERR_BITHIST_EN
      for (int h = 0; h < PW; h++) begin
         checks++;
         if (longint'(bit_err_hist[h*CW +: CW]) !== exp_hist[h]) begin
            errors++;
            $display("FAIL %s bit_hist[%0d] got=%0d want=%0d", name, h, bit_err_hist[h*CW +: CW], exp_hist[h]);
         end
      end
`endif
      hold_err = err_count; hold_sum = sum_abs_err; hold_max = max_abs_err;
      repeat (5) @(negedge clk);
      checks++;
      if (done !== 1'b1 || err_count !== hold_err || sum_abs_err !== hold_sum || max_abs_err !== hold_max) begin
         errors++;
         $display("FAIL %s hold_in_done got done=%b err=%0d sum=%0d max=%0d want done=1 err=%0d sum=%0d max=%0d",
                  name, done, err_count, sum_abs_err, max_abs_err, hold_err, hold_sum, hold_max);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({op_b, op_a, busy, done} !== '0 || err_count !== '0 || sum_abs_err !== '0 || max_abs_err !== '0) begin
         errors++;
         $display("FAIL reset_state got op=%h busy=%b done=%b err=%0d sum=%0d max=%0d want all 0",
                  {op_b, op_a}, busy, done, err_count, sum_abs_err, max_abs_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_abort();
      mode = 3;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({op_b, op_a, busy, done} !== '0 || err_count !== '0 || sum_abs_err !== '0 || max_abs_err !== '0) begin
         errors++;
         $display("FAIL abort_reset got op=%h busy=%b done=%b err=%0d sum=%0d max=%0d want all 0",
                  {op_b, op_a}, busy, done, err_count, sum_abs_err, max_abs_err);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b done=%b want 0/0", busy, done);
      end
      sweep_scenario("after_abort", 3, -1);
   endtask

   task automatic test_restart();
      int latency, busy_cnt;
      bit op_ok;
      longint err_at_start;
      sweep_scenario("repulse_in_sweep", 1, 50);
      mode = 1;
      build_expected(1);
      run_sweep(-1, latency, busy_cnt, op_ok, err_at_start);
      checks++;
      if (err_at_start !== 0) begin
         errors++;
         $display("FAIL restart_clear got=%0d want=0", err_at_start);
      end
      checks++;
      if (latency !== NV + 2 || longint'(err_count) !== exp_err || longint'(sum_abs_err) !== exp_sum
          || longint'(max_abs_err) !== exp_max) begin
         errors++;
         $display("FAIL restart_results got lat=%0d err=%0d sum=%0d max=%0d want lat=%0d err=%0d sum=%0d max=%0d",
                  latency, err_count, sum_abs_err, max_abs_err, NV + 2, exp_err, exp_sum, exp_max);
      end
   endtask

   initial begin
      for (int i = 0; i < NV; i++)
         rnd_mask[i] = ($urandom_range(0, 3) == 0) ? PW'($urandom) : '0;
      test_reset();
      sweep_scenario("exact", 0, -1);
      sweep_scenario("zero", 1, -1);
      sweep_scenario("plus_one", 2, -1);
      sweep_scenario("random_err", 3, -1);
      test_abort();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
